// File: rtl/vj_fx_pkg.sv
// Shared types and default widths for the fixed-point Viola-Jones stage evaluator.
// Saturating accumulate is selected with `define STAGE_EVAL_SAT_EN.
package vj_fx_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_FRAC_W   = 12;
    localparam int DEF_ACC_W    = 24;
    localparam int DEF_MAX_FEAT = 256;
    localparam int DEF_CNT_W    = $clog2(DEF_MAX_FEAT + 1);

    typedef logic signed [DEF_DATA_W-1:0] data_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;
    typedef logic [DEF_CNT_W-1:0]         cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        RESULT
    } state_t;

    function automatic acc_t sat_add(acc_t a, acc_t b);
        acc_t s;
        s = a + b;
        if (a[DEF_ACC_W-1] == b[DEF_ACC_W-1] && s[DEF_ACC_W-1] != a[DEF_ACC_W-1])
            s = a[DEF_ACC_W-1] ? {1'b1, {(DEF_ACC_W-1){1'b0}}}
                               : {1'b0, {(DEF_ACC_W-1){1'b1}}};
        return s;
    endfunction

endpackage

// File: rtl/weak_clf_fx.sv
// Weak classifier datapath: P1 scaled node threshold, P2 left/right alpha select.
// Valid/last sidebands travel with the data; flush_i drops everything in flight.
module weak_clf_fx
    import vj_fx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    input  logic                     in_last_i,
    input  logic signed [DATA_W-1:0] feat_sum_i,
    input  logic signed [DATA_W-1:0] node_thr_i,
    input  logic signed [DATA_W-1:0] alpha_l_i,
    input  logic signed [DATA_W-1:0] alpha_r_i,
    input  logic [DATA_W-1:0]        var_norm_i,
    output logic                     out_valid_o,
    output logic                     out_last_o,
    output logic signed [DATA_W-1:0] alpha_o
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]     thr_x, norm_x, prod_d, prod_q, thr_s, sum_x;
    logic signed [DATA_W-1:0] sum_q, al_q, ar_q, alpha_q;
    logic                     v1_q, l1_q, v2_q, l2_q;

    // Norm is unsigned: zero-extend so the product stays a signed PW value.
    assign thr_x  = {{DATA_W{node_thr_i[DATA_W-1]}}, node_thr_i};
    assign norm_x = {{DATA_W{1'b0}}, var_norm_i};
    assign prod_d = thr_x * norm_x;
    assign thr_s  = prod_q >>> FRAC_W;
    assign sum_x  = {{DATA_W{sum_q[DATA_W-1]}}, sum_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q    <= 1'b0;
            l1_q    <= 1'b0;
            v2_q    <= 1'b0;
            l2_q    <= 1'b0;
            prod_q  <= '0;
            sum_q   <= '0;
            al_q    <= '0;
            ar_q    <= '0;
            alpha_q <= '0;
        end else if (flush_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= in_valid_i;
            v2_q <= v1_q;
            if (in_valid_i) begin
                prod_q <= prod_d;
                sum_q  <= feat_sum_i;
                al_q   <= alpha_l_i;
                ar_q   <= alpha_r_i;
                l1_q   <= in_last_i;
            end
            if (v1_q) begin
                alpha_q <= (sum_x < thr_s) ? al_q : ar_q;
                l2_q    <= l1_q;
            end
        end
    end

    assign out_valid_o = v2_q;
    assign out_last_o  = l2_q;
    assign alpha_o     = alpha_q;

endmodule

// File: rtl/stage_eval_fx.sv
// Stage evaluator top: window FSM, alpha accumulator, beat counter, result regs.
// `define STAGE_EVAL_SAT_EN makes the accumulator saturate instead of wrap.
module stage_eval_fx
    import vj_fx_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int FRAC_W   = DEF_FRAC_W,
    parameter  int ACC_W    = DEF_ACC_W,
    parameter  int MAX_FEAT = DEF_MAX_FEAT,
    localparam int CNT_W    = $clog2(MAX_FEAT + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     abort_i,
    input  logic                     feat_valid_i,
    output logic                     feat_ready_o,
    input  logic signed [DATA_W-1:0] feat_sum_i,
    input  logic signed [DATA_W-1:0] node_thr_i,
    input  logic signed [DATA_W-1:0] alpha_l_i,
    input  logic signed [DATA_W-1:0] alpha_r_i,
    input  logic                     feat_last_i,
    input  logic [DATA_W-1:0]        var_norm_i,
    input  logic signed [ACC_W-1:0]  stage_thr_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic                     res_pass_o,
    output logic signed [ACC_W-1:0]  res_sum_o,
    output logic [CNT_W-1:0]         res_cnt_o,
    output logic                     res_ovf_o
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                    state_q;
    logic                      ready_q, ovf_q, p3_last_q, cmp_done_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d, thr_q, alpha_x;
    logic [ACC_W:0]            acc_wide;
    logic [CNT_W-1:0]          cnt_q, cnt_inc;
    logic                      res_valid_q, res_pass_q, res_ovf_q;
    logic signed [ACC_W-1:0]   res_sum_q;
    logic [CNT_W-1:0]          res_cnt_q;
    logic                      accept, hit_max, eff_last;
    logic                      clf_valid, clf_last;
    logic signed [DATA_W-1:0]  clf_alpha;

    assign accept   = feat_valid_i & ready_q & ~abort_i;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign hit_max  = (cnt_inc == CNT_W'(MAX_FEAT));
    assign eff_last = feat_last_i | hit_max;

    weak_clf_fx #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_clf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (abort_i),
        .in_valid_i  (accept),
        .in_last_i   (eff_last),
        .feat_sum_i  (feat_sum_i),
        .node_thr_i  (node_thr_i),
        .alpha_l_i   (alpha_l_i),
        .alpha_r_i   (alpha_r_i),
        .var_norm_i  (var_norm_i),
        .out_valid_o (clf_valid),
        .out_last_o  (clf_last),
        .alpha_o     (clf_alpha)
    );

    assign alpha_x = ACC_W'(clf_alpha);

    always_comb begin
        acc_wide = {acc_q[ACC_W-1], acc_q} + {alpha_x[ACC_W-1], alpha_x};
        acc_d    = acc_wide[ACC_W-1:0];
`ifdef STAGE_EVAL_SAT_EN
        if (acc_wide[ACC_W] != acc_wide[ACC_W-1])
            acc_d = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            thr_q       <= '0;
            p3_last_q   <= 1'b0;
            cmp_done_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_pass_q  <= 1'b0;
            res_sum_q   <= '0;
            res_cnt_q   <= '0;
            res_ovf_q   <= 1'b0;
        end else if (abort_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            p3_last_q   <= 1'b0;
            cmp_done_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            if (clf_valid)
                acc_q <= acc_d;
            p3_last_q <= clf_valid & clf_last;
            if (accept) begin
                cnt_q <= cnt_inc;
                if (eff_last) begin
                    thr_q <= stage_thr_i;
                    ovf_q <= ~feat_last_i;
                end
            end
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        state_q <= eff_last ? DRAIN : ACCUM;
                        ready_q <= ~eff_last;
                    end
                end
                DRAIN: begin
                    // Compare is registered one cycle after the last alpha lands.
                    if (p3_last_q) begin
                        res_pass_q <= (acc_q >= thr_q);
                        res_sum_q  <= acc_q;
                        res_cnt_q  <= cnt_q;
                        res_ovf_q  <= ovf_q;
                        cmp_done_q <= 1'b1;
                    end
                    if (cmp_done_q) begin
                        cmp_done_q  <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign feat_ready_o = ready_q;
    assign res_valid_o  = res_valid_q;
    assign res_pass_o   = res_pass_q;
    assign res_sum_o    = res_sum_q;
    assign res_cnt_o    = res_cnt_q;
    assign res_ovf_o    = res_ovf_q;

endmodule
